// File: rtl/svc_ice40_pll_rst.sv
// Lock-qualified reset sequencer for the iCE40 PLL output clock domain.
// Releases a registered synchronous reset once PLL lock has been stable for a programmable time.
module svc_ice40_pll_rst #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RST_HOLD_CYCLES    = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_lock_i,
  output logic       rst_o,
  output logic       rst_n_o,
  output logic       locked_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int unsigned MAX_CYCLES = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                                       LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int unsigned LOSS_W     = 8;

  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX    = {LOSS_W{1'b1}};

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [LOSS_W-1:0]      r_loss_cnt;
  logic                   r_rst;
  logic                   r_rst_n;

  state_t                 w_next_state;
  logic [CNT_W-1:0]       w_next_cnt;
  logic                   w_loss_inc;
  logic                   w_lock_s;

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  // Lock synchronizer; cleared on reset so qualification always restarts from scratch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock_i};
    end
  end

  // State, counter, loss counter and reset output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_RESET;
      r_cnt      <= '0;
      r_loss_cnt <= '0;
      r_rst      <= 1'b1;
      r_rst_n    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_rst   <= (w_next_state != ST_RUN);
      r_rst_n <= (w_next_state == ST_RUN);
      if (w_loss_inc && (r_loss_cnt != LOSS_MAX)) begin
        r_loss_cnt <= r_loss_cnt + LOSS_W'(1);
      end
    end
  end

  // Next-state and counter logic; any drop of synchronized lock restarts qualification.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_loss_inc   = 1'b0;

    case (r_state)
      ST_RESET: begin
        w_next_state = ST_WAIT_LOCK;
        w_next_cnt   = '0;
      end

      ST_WAIT_LOCK: begin
        w_next_cnt = '0;
        if (w_lock_s) begin
          w_next_state = ST_STABLE;
        end
      end

      ST_STABLE: begin
        if (!w_lock_s) begin
          w_next_state = ST_WAIT_LOCK;
          w_next_cnt   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_next_state = ST_HOLD;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (!w_lock_s) begin
          w_next_state = ST_WAIT_LOCK;
          w_next_cnt   = '0;
        end else if (r_cnt == HOLD_LAST) begin
          w_next_state = ST_RUN;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end

      ST_RUN: begin
        w_next_cnt = '0;
        if (!w_lock_s) begin
          w_next_state = ST_WAIT_LOCK;
          w_loss_inc   = 1'b1;
        end
      end

      default: begin
        w_next_state = ST_RESET;
        w_next_cnt   = '0;
      end
    endcase
  end

  assign rst_o           = r_rst;
  assign rst_n_o         = r_rst_n;
  assign locked_o        = w_lock_s;
  assign lock_loss_cnt_o = r_loss_cnt;

endmodule
